eth_hdr_arbiter: RTL and testbench

ETH_HDR_ARBITER -- requirements
Module: eth_hdr_arbiter

---
 rtl/eth_encap_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/eth_hdr_arbiter.sv | 116 +++++++++++
 tb/tb_eth_hdr_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_encap_pkg.sv
// Shared definitions for the Ethernet encapsulation path.
// Holds MAC widths, EtherType constants and the arbiter state encoding.
package eth_encap_pkg;

    localparam int          MAC_W          = 48;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    function automatic int rr_pos(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester after last_grant, wrapping.
// Produces a one-hot grant plus its binary index.
module rr_arbiter
    import eth_encap_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               req_any
);

    always_comb begin
        gnt     = '0;
        idx     = '0;
        req_any = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int k;
            k = rr_pos(int'(last_grant), i, NUM_REQ);
            if (!req_any && req[k]) begin
                req_any = 1'b1;
                gnt[k]  = 1'b1;
                idx     = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/eth_hdr_arbiter.sv
// Arbitrates requesters for the Ethernet header builder, one frame at a time,
// with a watchdog that aborts frames that never signal frame_done.
module eth_hdr_arbiter
    import eth_encap_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [MAC_W*NUM_REQ-1:0]   req_dst_mac,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       hdr_valid,
    output logic [MAC_W-1:0]           hdr_dst_mac,
    output logic [MAC_W-1:0]           hdr_src_mac,
    input  logic                       hdr_ready,
    input  logic                       frame_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [MAC_W-1:0]   dst_q, dst_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [ID_W-1:0]    rr_idx;
    logic               rr_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (rr_gnt),
        .idx        (rr_idx),
        .req_any    (rr_any)
    );

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        terr_d    = 1'b0;
        req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Grant is combinational; gated so reset never acks a request.
                if (rr_any && !rst) begin
                    req_ready = rr_gnt;
                    dst_d     = req_dst_mac[int'(rr_idx)*MAC_W +: MAC_W];
                    grant_d   = rr_idx;
                    last_d    = rr_idx;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_ready) begin
                    cnt_d   = '0;
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (frame_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dst_q   <= '0;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign hdr_valid   = (state_q == ST_HDR);
    assign busy        = (state_q != ST_IDLE);
    assign hdr_dst_mac = dst_q;
    assign hdr_src_mac = SRC_MAC;
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_eth_hdr_arbiter.sv
// Scenario bench for eth_hdr_arbiter: expected headers are queued at grant
// time and popped when the builder accepts them.
module tb_eth_hdr_arbiter;

    localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [191:0] req_dst_mac;
    logic [3:0]   req_ready;
    logic         hdr_valid;
    logic [47:0]  hdr_dst_mac;
    logic [47:0]  hdr_src_mac;
    logic         hdr_ready;
    logic         frame_done;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    typedef struct packed {
        logic [1:0]  id;
        logic [47:0] mac;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    eth_hdr_arbiter #(
        .NUM_REQ     (4),
        .SRC_MAC     (SRC),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_dst_mac (req_dst_mac),
        .req_ready   (req_ready),
        .hdr_valid   (hdr_valid),
        .hdr_dst_mac (hdr_dst_mac),
        .hdr_src_mac (hdr_src_mac),
        .hdr_ready   (hdr_ready),
        .frame_done  (frame_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [47:0] mac_of(input int i);
        logic [47:0] m;
        m = (i == 2) ? 48'hAABBCCDDEEFF : (48'h0011_2233_4400 + 48'(i));
        return m;
    endfunction

    // Scoreboard side: header accepted by builder must match the queued grant.
    always @(negedge clk) begin
        if (req_ready != 4'b0000) begin
            total++;
            if ($countones(req_ready) != 1) begin
                bad++;
                $display("FAIL onehot: req_ready=%b expected one bit", req_ready);
            end
        end
        if (!rst && hdr_valid && hdr_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: header id=%0d mac=%h unexpected",
                         grant_id, hdr_dst_mac);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (grant_id !== e.id || hdr_dst_mac !== e.mac
                    || hdr_src_mac !== SRC) begin
                    bad++;
                    $display("FAIL sb_hdr: got id=%0d dst=%h src=%h exp id=%0d dst=%h src=%h",
                             grant_id, hdr_dst_mac, hdr_src_mac, e.id, e.mac, SRC);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carries a granted frame through HDR (one cycle) and a 1-cycle FRAME.
    task automatic serve(input logic [3:0] rv_after);
        tick();
        req_valid = rv_after;
        hdr_ready = 1'b1;
        tick();
        hdr_ready  = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '0;
        hdr_ready  = 1'b0;
        frame_done = 1'b0;
        for (int i = 0; i < 4; i++) req_dst_mac[48*i +: 48] = mac_of(i);
        tick();
        tick();
        total++;
        if (hdr_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0
            || hdr_dst_mac !== 48'h0 || timeout_err !== 1'b0
            || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_vals: hv=%b busy=%b gid=%0d dst=%h terr=%b rr=%b exp all zero",
                     hdr_valid, busy, grant_id, hdr_dst_mac, timeout_err, req_ready);
        end
        total++;
        if (hdr_src_mac !== SRC) begin
            bad++;
            $display("FAIL src_mac: got %h exp %h", hdr_src_mac, SRC);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_id;
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_id = j % 4;
            #1;
            total++;
            if (req_ready !== (4'b0001 << exp_id) || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_grant%0d: req_ready=%b busy=%b exp %b busy=0",
                         j, req_ready, busy, 4'b0001 << exp_id);
            end
            sb_q.push_back('{id: 2'(exp_id), mac: mac_of(exp_id)});
            tick();
            total++;
            if (req_ready !== 4'b0000 || hdr_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_pulse%0d: req_ready=%b hv=%b exp 0000 hv=1",
                         j, req_ready, hdr_valid);
            end
            hdr_ready = 1'b1;
            tick();
            hdr_ready = 1'b0;
            tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_hdr_hold();
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL hold_grant: req_ready=%b exp 0100", req_ready);
        end
        sb_q.push_back('{id: 2'd2, mac: 48'hAABBCCDDEEFF});
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (hdr_valid !== 1'b1 || hdr_dst_mac !== 48'hAABBCCDDEEFF
                || hdr_src_mac !== SRC || busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_cyc%0d: hv=%b dst=%h src=%h busy=%b exp 1 AABBCCDDEEFF",
                         i, hdr_valid, hdr_dst_mac, hdr_src_mac, busy);
            end
            frame_done = (i == 2);
            hdr_ready  = (i == 5);
            tick();
        end
        hdr_ready  = 1'b0;
        frame_done = 1'b0;
        total++;
        if (hdr_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_exit: hv=%b busy=%b exp hv=0 busy=1", hdr_valid, busy);
        end
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (busy !== 1'b0 || grant_id !== 2'd2 || hdr_dst_mac !== 48'hAABBCCDDEEFF) begin
            bad++;
            $display("FAIL idle_hold: busy=%b gid=%0d dst=%h exp 0 2 AABBCCDDEEFF",
                     busy, grant_id, hdr_dst_mac);
        end
    endtask

    task automatic test_timeout();
        logic exp_err;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL to_grant: req_ready=%b exp 0001", req_ready);
        end
        sb_q.push_back('{id: 2'd0, mac: mac_of(0)});
        tick();
        req_valid = 4'b0000;
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_err = (k == 16);
            total++;
            if (timeout_err !== exp_err || busy !== !exp_err) begin
                bad++;
                $display("FAIL to_cyc%0d: terr=%b busy=%b exp terr=%b busy=%b",
                         k, timeout_err, busy, exp_err, !exp_err);
            end
        end
        tick();
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_after: terr=%b busy=%b exp 0 0", timeout_err, busy);
        end
    endtask

    task automatic test_coincide();
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL co_grant: req_ready=%b exp 0010", req_ready);
        end
        sb_q.push_back('{id: 2'd1, mac: mac_of(1)});
        tick();
        req_valid = 4'b0000;
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        repeat (15) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL co_edge: terr=%b busy=%b exp 0 0", timeout_err, busy);
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b0 || hdr_valid !== 1'b0
            || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL co_idle_fd: terr=%b busy=%b hv=%b gid=%0d exp 0 0 0 1",
                     timeout_err, busy, hdr_valid, grant_id);
        end
    endtask

    task automatic test_reset_mid_frame();
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL rm_grant: req_ready=%b exp 0010", req_ready);
        end
        sb_q.push_back('{id: 2'd1, mac: mac_of(1)});
        tick();
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (hdr_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0
            || hdr_dst_mac !== 48'h0 || timeout_err !== 1'b0
            || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rm_reset: hv=%b busy=%b gid=%0d dst=%h terr=%b rr=%b exp all zero",
                     hdr_valid, busy, grant_id, hdr_dst_mac, timeout_err, req_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL rm_regrant: req_ready=%b exp 0010", req_ready);
        end
        sb_q.push_back('{id: 2'd1, mac: mac_of(1)});
        tick();
        total++;
        if (hdr_valid !== 1'b1 || grant_id !== 2'd1 || hdr_dst_mac !== mac_of(1)
            || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL rm_hdr: hv=%b gid=%0d dst=%h terr=%b exp 1 1 %h 0",
                     hdr_valid, grant_id, hdr_dst_mac, timeout_err, mac_of(1));
        end
        req_valid = 4'b0000;
        hdr_ready = 1'b1;
        tick();
        hdr_ready  = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic test_wrap();
        req_valid = 4'b1000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL wr_g3: req_ready=%b exp 1000", req_ready);
        end
        sb_q.push_back('{id: 2'd3, mac: mac_of(3)});
        serve(4'b0000);
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL wr_g0: req_ready=%b exp 0001", req_ready);
        end
        sb_q.push_back('{id: 2'd0, mac: mac_of(0)});
        serve(4'b1001);
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL wr_g3b: req_ready=%b exp 1000", req_ready);
        end
        sb_q.push_back('{id: 2'd3, mac: mac_of(3)});
        serve(4'b0000);
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hdr_hold();
        test_timeout();
        test_coincide();
        test_reset_mid_frame();
        test_wrap();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_left: %0d headers never accepted, exp 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
